// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with a pixel-rate
// prescaler, programmable porches/sync polarity, and aligned pixel coordinates.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       1 = timing runs, 0 = freeze counters and level outputs
//   restart      synchronous pulse, jump to (0,0) on the next clk
//   pix_en       high in each clk cycle where hpos/vpos just advanced
//   hpos, vpos   current pixel column / line
//   hsync, vsync sync outputs, at H_POL/V_POL level while active
//   display_on   inside the visible area
//   line_start   one-clk pulse on entry to hpos==0
//   frame_start  one-clk pulse on entry to (0,0)
//   frame_count  frames started since reset, wraps
module video_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CLK_DIV   = 1,
    parameter int POS_W     = 10,
    parameter int FC_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             restart,
    output logic             pix_en,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
        $error("video_timing_gen: porch and sync widths must be >= 1");
    end

    if (CLK_DIV < 1) begin : g_bad_div
        $error("video_timing_gen: CLK_DIV must be >= 1");
    end

    if (POS_W < 1 || POS_W > 31 ||
        longint'(H_TOTAL) > (longint'(1) << POS_W) ||
        longint'(V_TOTAL) > (longint'(1) << POS_W)) begin : g_bad_posw
        $error("video_timing_gen: POS_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_DISP   = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_DISP   = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] HS_BEG   = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] HS_END   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_BEG   = POS_W'(V_DISPLAY + V_FRONT);
    localparam logic [POS_W-1:0] VS_END   = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic             H_LVL    = (H_POL != 0);
    localparam logic             V_LVL    = (V_POL != 0);

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic [POS_W-1:0] h_nxt;
    logic [POS_W-1:0] v_nxt;
    logic             tick;
    logic             step;
    logic             hs_act;
    logic             vs_act;
    logic             vis_nxt;
    logic             line_entry;
    logic             frame_entry;
    // Suppresses the frame_count increment on the first (0,0) entry
    logic             started;

    always_comb begin
        tick    = enable && (pre == PRE_LAST);
        step    = restart || tick;
        pre_nxt = pre;
        h_nxt   = hpos;
        v_nxt   = vpos;
        if (restart) begin
            pre_nxt = '0;
            h_nxt   = '0;
            v_nxt   = '0;
        end else if (tick) begin
            pre_nxt = '0;
            if (hpos == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vpos == V_LAST) ? '0 : vpos + POS_W'(1);
            end else begin
                h_nxt = hpos + POS_W'(1);
            end
        end else if (enable) begin
            pre_nxt = pre + PRE_W'(1);
        end
    end

    // Decode from next-state counters so registered outputs line up with hpos/vpos
    always_comb begin
        hs_act      = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
        vs_act      = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
        vis_nxt     = (h_nxt < H_DISP) && (v_nxt < V_DISP);
        line_entry  = step && (h_nxt == '0);
        frame_entry = line_entry && (v_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre         <= '0;
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            hsync       <= ~H_LVL;
            vsync       <= ~V_LVL;
            display_on  <= 1'b0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            started     <= 1'b0;
        end else begin
            pre         <= pre_nxt;
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= hs_act ? H_LVL : ~H_LVL;
            vsync       <= vs_act ? V_LVL : ~V_LVL;
            display_on  <= vis_nxt;
            pix_en      <= step;
            line_start  <= line_entry;
            frame_start <= frame_entry;
            if (frame_entry) begin
                started <= 1'b1;
                if (started) begin
                    frame_count <= frame_count + FC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed test of video_timing_gen on a 16x8 raster,
// one instance at CLK_DIV=1/active-low, one at CLK_DIV=4/active-high/FC_W=2.
module tb_video_timing_gen;

    localparam int HT = 16;
    localparam int VT = 8;
    localparam int NP = HT * VT;

    logic clk;
    logic rst_n;
    logic enable;
    logic restart;

    logic       pix_en_a, hsync_a, vsync_a, disp_a, ls_a, fs_a;
    logic [9:0] hpos_a, vpos_a;
    logic [7:0] fc_a;
    logic       pix_en_b, hsync_b, vsync_b, disp_b, ls_b, fs_b;
    logic [9:0] hpos_b, vpos_b;
    logic [1:0] fc_b;

    int vectors = 0;
    int miscompares = 0;
    int fail_prints = 0;
    bit chk_on = 0;

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(1), .POS_W(10), .FC_W(8)
    ) dut_a (
        .clk(clk), .reset_n(rst_n), .enable(enable), .restart(restart),
        .pix_en(pix_en_a), .hpos(hpos_a), .vpos(vpos_a),
        .hsync(hsync_a), .vsync(vsync_a), .display_on(disp_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_POL(1), .V_POL(1), .CLK_DIV(4), .POS_W(10), .FC_W(2)
    ) dut_b (
        .clk(clk), .reset_n(rst_n), .enable(enable), .restart(restart),
        .pix_en(pix_en_b), .hpos(hpos_b), .vpos(vpos_b),
        .hsync(hsync_b), .vsync(vsync_b), .display_on(disp_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: linear pixel index within the frame, ticks from a clock divider
    int m_p[2];
    int m_pre[2];
    int m_fc[2];
    bit m_pe[2];
    bit m_first[2];

    function automatic int div_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int mod_of(int i);
        return (i == 0) ? 256 : 4;
    endfunction

    function automatic bit pol_of(int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_p[i]     <= NP - 1;
                m_pre[i]   <= 0;
                m_fc[i]    <= 0;
                m_pe[i]    <= 0;
                m_first[i] <= 1;
            end else if (restart) begin
                m_p[i]     <= 0;
                m_pre[i]   <= 0;
                m_pe[i]    <= 1;
                m_first[i] <= 0;
                m_fc[i]    <= m_first[i] ? m_fc[i] : (m_fc[i] + 1) % mod_of(i);
            end else if (enable && m_pre[i] == div_of(i) - 1) begin
                m_p[i]   <= (m_p[i] + 1) % NP;
                m_pre[i] <= 0;
                m_pe[i]  <= 1;
                if ((m_p[i] + 1) % NP == 0) begin
                    m_first[i] <= 0;
                    m_fc[i]    <= m_first[i] ? m_fc[i] : (m_fc[i] + 1) % mod_of(i);
                end
            end else begin
                m_pe[i] <= 0;
                if (enable) m_pre[i] <= m_pre[i] + 1;
            end
        end
    end

    function automatic logic [33:0] exp_vec(int i);
        int  h, v;
        bit  hs, vs, dsp, ls, fs;
        h   = m_p[i] % HT;
        v   = m_p[i] / HT;
        hs  = (h >= 10 && h <= 12) ? pol_of(i) : ~pol_of(i);
        vs  = (v >= 5 && v <= 6) ? pol_of(i) : ~pol_of(i);
        dsp = (h < 8) && (v < 4);
        ls  = m_pe[i] && (h == 0);
        fs  = m_pe[i] && (m_p[i] == 0);
        return {m_pe[i], 10'(h), 10'(v), hs, vs, dsp, ls, fs, 8'(m_fc[i])};
    endfunction

    function automatic logic [33:0] act_vec(int i);
        if (i == 0)
            return {pix_en_a, hpos_a, vpos_a, hsync_a, vsync_a,
                    disp_a, ls_a, fs_a, fc_a};
        return {pix_en_b, hpos_b, vpos_b, hsync_b, vsync_b,
                disp_b, ls_b, fs_b, 6'd0, fc_b};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (act_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    if (fail_prints < 20) begin
                        fail_prints++;
                        $display("FAIL model_%0d t=%0t got=%h exp=%h",
                                 i, $time, act_vec(i), exp_vec(i));
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    int disp_cnt, fs_cnt, ls_cnt, fs_bad, fc_bad, hs_bad, vs_bad;
    int pe_b_cnt, ls_b_cnt;
    int got_fs, seq_bad, budget, last_fc, frz_bad, fc0;
    bit found;

    initial begin
        rst_n   = 1;
        enable  = 0;
        restart = 0;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        chk_on = 1;

        chk("rst_hpos_a", hpos_a, 15);
        chk("rst_vpos_a", vpos_a, 7);
        chk("rst_hsync_a", hsync_a, 1);
        chk("rst_vsync_a", vsync_a, 1);
        chk("rst_disp_a", disp_a, 0);
        chk("rst_pix_en_a", pix_en_a, 0);
        chk("rst_fs_a", fs_a, 0);
        chk("rst_fc_a", fc_a, 0);
        chk("rst_hsync_b", hsync_b, 0);
        chk("rst_vsync_b", vsync_b, 0);

        enable = 1;
        rst_n  = 1;
        @(negedge clk);
        chk("first_hpos_a", hpos_a, 0);
        chk("first_vpos_a", vpos_a, 0);
        chk("first_fs_a", fs_a, 1);
        chk("first_ls_a", ls_a, 1);
        chk("first_fc_a", fc_a, 0);
        chk("first_pix_en_a", pix_en_a, 1);
        chk("first_hpos_b", hpos_b, 15);
        chk("first_pix_en_b", pix_en_b, 0);

        disp_cnt = 0; fs_cnt = 0; ls_cnt = 0; fs_bad = 0; fc_bad = 0;
        hs_bad = 0; vs_bad = 0; pe_b_cnt = 0; ls_b_cnt = 0;
        for (int c = 0; c < 3 * NP; c++) begin
            if (c > 0) @(negedge clk);
            disp_cnt += int'(disp_a);
            ls_cnt   += int'(ls_a);
            if (fs_a) begin
                if (c != fs_cnt * NP) fs_bad++;
                if (int'(fc_a) != fs_cnt) fc_bad++;
                fs_cnt++;
            end
            if (hsync_a != !(hpos_a >= 10 && hpos_a <= 12)) hs_bad++;
            if (vsync_a != !(vpos_a >= 5 && vpos_a <= 6)) vs_bad++;
            pe_b_cnt += int'(pix_en_b);
            ls_b_cnt += int'(ls_b);
        end
        chk("disp_clks_3f", disp_cnt, 96);
        chk("fs_count_3f", fs_cnt, 3);
        chk("fs_period", fs_bad, 0);
        chk("fc_sequence", fc_bad, 0);
        chk("ls_count_3f", ls_cnt, 24);
        chk("hsync_window", hs_bad, 0);
        chk("vsync_window", vs_bad, 0);
        chk("pix_en_b_count", pe_b_cnt, 96);
        chk("ls_b_count", ls_b_cnt, 6);

        got_fs = 0; seq_bad = 0; budget = 3000; last_fc = -1;
        while (got_fs < 4 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (fs_b) begin
                if (int'(fc_b) != (got_fs + 1) % 4) seq_bad++;
                last_fc = int'(fc_b);
                got_fs++;
            end
        end
        chk("fc_b_frames", got_fs, 4);
        chk("fc_b_wrap_seq", seq_bad, 0);
        chk("fc_b_wrapped", last_fc, 0);

        found = 0;
        budget = 40;
        while (!found && budget > 0) begin
            @(negedge clk);
            budget--;
            found = (hpos_a == 10'd5) && pix_en_a;
        end
        chk("find_hpos5", found, 1);
        enable = 0;
        frz_bad = 0;
        repeat (7) begin
            @(negedge clk);
            if (hpos_a != 10'd5 || pix_en_a || ls_a || fs_a || pix_en_b) frz_bad++;
        end
        chk("freeze", frz_bad, 0);
        enable = 1;
        @(negedge clk);
        chk("resume_hpos", hpos_a, 6);
        chk("resume_pix_en", pix_en_a, 1);

        found = 0;
        budget = 200;
        while (!found && budget > 0) begin
            @(negedge clk);
            budget--;
            found = (hpos_a == 10'd11) && (vpos_a == 10'd6);
        end
        chk("find_11_6", found, 1);
        chk("in_hsync", hsync_a, 0);
        chk("in_vsync", vsync_a, 0);
        fc0 = m_fc[0];
        restart = 1;
        @(negedge clk);
        chk("rs_hpos", hpos_a, 0);
        chk("rs_vpos", vpos_a, 0);
        chk("rs_hsync", hsync_a, 1);
        chk("rs_vsync", vsync_a, 1);
        chk("rs_fs", fs_a, 1);
        chk("rs_fc", fc_a, (fc0 + 1) % 256);
        chk("rs_hpos_b", hpos_b, 0);
        chk("rs_fs_b", fs_b, 1);
        chk("rs_hsync_b", hsync_b, 0);
        @(negedge clk);
        chk("rs2_fs", fs_a, 1);
        chk("rs2_hpos", hpos_a, 0);
        chk("rs2_fc", fc_a, (fc0 + 2) % 256);
        restart = 0;
        @(negedge clk);
        chk("post_rs_hpos", hpos_a, 1);
        chk("post_rs_fs", fs_a, 0);
        chk("post_rs_pix_en_b", pix_en_b, 0);

        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_hpos_a", hpos_a, 15);
        chk("async_vpos_a", vpos_a, 7);
        chk("async_pix_en_a", pix_en_a, 0);
        chk("async_fc_a", fc_a, 0);
        chk("async_disp_a", disp_a, 0);
        chk("async_hsync_b", hsync_b, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rerun_fs_a", fs_a, 1);
        chk("rerun_fc_a", fc_a, 0);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
